trig_acq_ctrl: RTL and testbench

Acquisition sequencer for the ADC trigger path.
- Owns the trigger level fed to the trigger comparator. The level can only change between captures.
- Sequences one capture into a circular sample RAM: pre-trigger fill, wait for trigger, post-trigger count, readout handshake, holdoff.
- Produces the RAM write strobe and address, and records the address of the trigger sample.

---
 rtl/trig_acq_ctrl.sv | 149 ++++++++++++++
 tb/tb_trig_acq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trig_acq_ctrl.sv
// Trigger acquisition sequencer: owns the comparator level and sequences one capture
// (pre-fill, wait, post, readout, holdoff). Optional macro AUTO_TRIG_EN adds a WAIT timeout.
module trig_acq_ctrl #(
    parameter int ADDR_W       = 10,
    parameter int CNT_W        = 16,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ack,
    input  logic              trg_in,
    input  logic [13:0]       cfg_level,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] post_len,
    input  logic [CNT_W-1:0]  holdoff,
    output logic [13:0]       trg_level,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] trg_addr,
    output logic              busy,
    output logic              done,
    output logic              auto_trg,
    output logic [CNT_W-1:0]  trg_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE, S_HOLD
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n, post_eff, post_eff_n, wr_addr_n, trg_addr_n;
    logic [ADDR_W-1:0] room;
    logic [CNT_W-1:0]  hcnt, hcnt_n, trg_count_n;
    logic [13:0]       trg_level_n;
    logic              auto_trg_n;
    logic              timeout_hit, trig_hit;

`ifdef AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TO_W-1:0] tcnt;

    // Held at zero outside WAIT, so it restarts from zero on every WAIT entry.
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) tcnt <= '0;
        else                        tcnt <= tcnt + 1'b1;
    end

    assign timeout_hit = (state == S_WAIT) && (tcnt == TO_W'(AUTO_TIMEOUT - 1));
`else
    assign timeout_hit = (AUTO_TIMEOUT < 0);
`endif

    // pre_len already fits in DEPTH-1, so the space left for post samples is its complement.
    assign room     = ~pre_len;
    assign trig_hit = trg_in || timeout_hit;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        post_eff_n  = post_eff;
        hcnt_n      = hcnt;
        wr_addr_n   = wr_addr;
        trg_addr_n  = trg_addr;
        trg_level_n = trg_level;
        auto_trg_n  = auto_trg;
        trg_count_n = trg_count;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    trg_level_n = cfg_level;
                    post_eff_n  = (post_len > room) ? room : post_len;
                    hcnt_n      = holdoff;
                    wr_addr_n   = '0;
                    auto_trg_n  = 1'b0;
                    cnt_n       = pre_len;
                    state_n     = (pre_len == '0) ? S_WAIT : S_PRE;
                end
            end
            S_PRE: begin
                wr_addr_n = wr_addr + 1'b1;
                cnt_n     = cnt - 1'b1;
                if (cnt == ADDR_W'(1)) state_n = S_WAIT;
            end
            S_WAIT: begin
                wr_addr_n = wr_addr + 1'b1;
                if (trig_hit) begin
                    trg_addr_n = wr_addr;
                    auto_trg_n = !trg_in;
                    cnt_n      = post_eff;
                    state_n    = (post_eff == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                wr_addr_n = wr_addr + 1'b1;
                cnt_n     = cnt - 1'b1;
                if (cnt == ADDR_W'(1)) state_n = S_DONE;
            end
            S_DONE: begin
                if (ack) state_n = (hcnt != '0) ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                hcnt_n = hcnt - 1'b1;
                if (hcnt == CNT_W'(1)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_n    = S_IDLE;
            wr_addr_n  = wr_addr;
            trg_addr_n = trg_addr;
            auto_trg_n = auto_trg;
        end
        if (state_n == S_DONE && state != S_DONE && trg_count != '1)
            trg_count_n = trg_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            post_eff  <= '0;
            hcnt      <= '0;
            wr_addr   <= '0;
            trg_addr  <= '0;
            trg_level <= 14'h2300;
            auto_trg  <= 1'b0;
            trg_count <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            post_eff  <= post_eff_n;
            hcnt      <= hcnt_n;
            wr_addr   <= wr_addr_n;
            trg_addr  <= trg_addr_n;
            trg_level <= trg_level_n;
            auto_trg  <= auto_trg_n;
            trg_count <= trg_count_n;
            wr_en     <= (state_n == S_PRE) || (state_n == S_WAIT) || (state_n == S_POST);
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_trig_acq_ctrl.sv
// Directed bench for trig_acq_ctrl (ADDR_W=4); write addresses are checked against a queue
// of expected addresses pushed as stimulus is driven.
module tb_trig_acq_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort, ack, trg_in;
    logic [13:0] cfg_level;
    logic [3:0]  pre_len, post_len;
    logic [15:0] holdoff;
    logic [13:0] trg_level;
    logic        wr_en, busy, done, auto_trg;
    logic [3:0]  wr_addr, trg_addr;
    logic [15:0] trg_count;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [3:0]  exp_q[$];

    trig_acq_ctrl #(.ADDR_W(4), .CNT_W(16), .AUTO_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ack(ack), .trg_in(trg_in),
        .cfg_level(cfg_level), .pre_len(pre_len), .post_len(post_len), .holdoff(holdoff),
        .trg_level(trg_level), .wr_en(wr_en), .wr_addr(wr_addr), .trg_addr(trg_addr),
        .busy(busy), .done(done), .auto_trg(auto_trg), .trg_count(trg_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [3:0] a, input int lim, input string tag);
        int n = 0;
        while (wr_addr !== a && n < lim) begin
            step();
            n++;
        end
        chk(tag, {31'd0, wr_addr === a}, 32'd1);
    endtask

    // Every write strobe must match the next expected address.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) chk("wr_unexpected", {28'd0, wr_addr}, 32'hFFFF_FFFF);
            else chk("wr_addr", {28'd0, wr_addr}, {28'd0, exp_q.pop_front()});
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0; trg_in = 1'b0;
        cfg_level = 14'h0; pre_len = 4'd0; post_len = 4'd0; holdoff = 16'd0;
        step(); step();
        chk("rst_level", trg_level, 32'h2300);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", trg_count, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_trg_addr", trg_addr, 0);
        chk("rst_auto", auto_trg, 0);
        rst = 1'b0;
        step();

        // 1: basic capture
        cfg_level = 14'h2000; pre_len = 4'd4; post_len = 4'd3; start = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(4'(i));
        step(); start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_level", trg_level, 32'h2000);
        wait_addr(4'd6, 20, "t1_reach_wait");
        trg_in = 1'b1;
        step(); trg_in = 1'b0;
        chk("t1_trg_addr", trg_addr, 6);
        chk("t1_post_addr", wr_addr, 7);
        step(); chk("t1_done_early", done, 0);
        step(); chk("t1_done_early", done, 0);
        step();
        chk("t1_done", done, 1);
        chk("t1_wr_en", wr_en, 0);
        chk("t1_count", trg_count, 1);
        step(); step();
        chk("t1_done_hold", done, 1);
        ack = 1'b1;
        step(); ack = 1'b0;
        chk("t1_ack_done", done, 0);
        chk("t1_ack_busy", busy, 0);

        // 2: maximum pre length leaves no room for post samples
        pre_len = 4'd15; post_len = 4'd15; start = 1'b1;
        for (int i = 0; i < 15; i++) exp_q.push_back(4'(i));
        step(); start = 1'b0;
        wait_addr(4'd15, 30, "t2_reach_wait");
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd0);
        step();
        exp_q.push_back(4'd1);
        step();
        trg_in = 1'b1;
        step(); trg_in = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_wr_en", wr_en, 0);
        chk("t2_trg_addr", trg_addr, 1);
        chk("t2_count", trg_count, 2);
        ack = 1'b1;
        step(); ack = 1'b0;
        chk("t2_idle", busy, 0);

        // 3: zero lengths with trigger already high
        pre_len = 4'd0; post_len = 4'd0; trg_in = 1'b1; start = 1'b1;
        exp_q.push_back(4'd0);
        step(); start = 1'b0;
        chk("t3_wait_wr", wr_en, 1);
        chk("t3_wait_done", done, 0);
        step(); trg_in = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_trg_addr", trg_addr, 0);
        chk("t3_count", trg_count, 3);
        ack = 1'b1;
        step(); ack = 1'b0;

        // 4: trigger coincident with last PRE write is ignored; abort in POST
        pre_len = 4'd2; post_len = 4'd5; trg_in = 1'b1; start = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(4'(i));
        step(); start = 1'b0;
        step();
        step();
        chk("t4_wait_addr", wr_addr, 2);
        step(); trg_in = 1'b0;
        chk("t4_trg_addr", trg_addr, 2);
        step();
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_wr", wr_en, 0);
        chk("t4_abort_done", done, 0);
        chk("t4_abort_trg_addr", trg_addr, 2);
        chk("t4_abort_count", trg_count, 3);

        // restart immediately, then 5: holdoff
        cfg_level = 14'h0ABC; pre_len = 4'd0; post_len = 4'd0; holdoff = 16'd5;
        trg_in = 1'b1; start = 1'b1;
        exp_q.push_back(4'd0);
        step(); start = 1'b0;
        chk("t4_restart_busy", busy, 1);
        step(); trg_in = 1'b0;
        chk("t4_restart_done", done, 1);
        chk("t4_restart_count", trg_count, 4);
        ack = 1'b1;
        step(); ack = 1'b0;
        cfg_level = 14'h3FFF;
        for (int i = 1; i <= 4; i++) begin
            start = (i % 2 == 1);
            step();
            chk("t5_hold_busy", busy, 1);
        end
        chk("t5_level_kept", trg_level, 32'h0ABC);
        start = 1'b1;
        step(); start = 1'b0;
        chk("t5_hold_end", busy, 0);

        // 6: no trigger; timeout behaviour depends on build
        cfg_level = 14'h1234; holdoff = 16'd0; start = 1'b1;
        exp_q.push_back(4'd0);
        step(); start = 1'b0;
        chk("t6_level", trg_level, 32'h1234);
`ifdef AUTO_TRIG_EN
        for (int i = 1; i < 8; i++) begin
            exp_q.push_back(4'(i));
            step();
        end
        chk("t6_pre_timeout_done", done, 0);
        chk("t6_pre_timeout_auto", auto_trg, 0);
        step();
        chk("t6_forced_done", done, 1);
        chk("t6_forced_addr", trg_addr, 7);
        chk("t6_auto", auto_trg, 1);
        ack = 1'b1;
        step(); ack = 1'b0;
        chk("t6_auto_hold", auto_trg, 1);
        trg_in = 1'b1; start = 1'b1;
        exp_q.push_back(4'd0);
        step(); start = 1'b0;
        chk("t6_auto_clear", auto_trg, 0);
        step(); trg_in = 1'b0;
        chk("t6_real_done", done, 1);
        chk("t6_real_auto", auto_trg, 0);
        chk("t6_count", trg_count, 6);
        ack = 1'b1;
        step(); ack = 1'b0;
`else
        for (int i = 1; i < 100; i++) begin
            exp_q.push_back(4'(i));
            step();
        end
        chk("t6_still_wait", busy, 1);
        chk("t6_no_done", done, 0);
        chk("t6_no_auto", auto_trg, 0);
        chk("t6_addr", wr_addr, 3);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("t6_abort", busy, 0);
        chk("t6_count", trg_count, 4);
`endif

        // reset mid-capture
        pre_len = 4'd3; start = 1'b1;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd1);
        step(); start = 1'b0;
        step();
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("mid_rst_level", trg_level, 32'h2300);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr", wr_en, 0);
        chk("mid_rst_count", trg_count, 0);
        step();
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
